// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature decoder with synchronizer, arming delay, loadable counter and sticky error
module quad_decoder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             clear_err,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       s1_q, s2_q, p_q;
  logic [1:0]       arm_q, arm_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             err_q, err_d;

  logic dec_en, is_up, is_dn, is_bad;

  always_comb begin
    is_up = 1'b0;
    is_dn = 1'b0;
    case ({p_q, s2_q})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: is_up = 1'b1;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: is_dn = 1'b1;
      default: ;
    endcase
    is_bad = ((p_q ^ s2_q) == 2'b11);
    // Decode stays off until the synchronizer and p hold real input samples.
    dec_en = (arm_q == 2'd3);
  end

  always_comb begin
    arm_d   = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
    count_d = count_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    err_d   = err_q;

    if (dec_en && (is_up || is_dn)) begin
      dir_d = is_up;
    end

    // Set wins over clear when both happen in one cycle.
    if (dec_en && is_bad) begin
      err_d = 1'b1;
    end else if (clear_err) begin
      err_d = 1'b0;
    end

    if (load) begin
      count_d = data;
    end else if (dec_en && is_up) begin
      count_d = count_q + ONE;
      step_d  = 1'b1;
    end else if (dec_en && is_dn) begin
      count_d = count_q - ONE;
      step_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 2'b00;
      s2_q    <= 2'b00;
      p_q     <= 2'b00;
      arm_q   <= 2'd0;
      count_q <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      s1_q    <= {a_in, b_in};
      s2_q    <= s1_q;
      p_q     <= s2_q;
      arm_q   <= arm_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      err_q   <= err_d;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign step  = step_q;
  assign err   = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - scoreboard bench for quad_decoder
module tb_quad_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_in, b_in;
  logic       load;
  logic [7:0] data;
  logic       clear_err;
  logic [7:0] count;
  logic       dir, step, err;

  quad_decoder #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .load(load),
    .data(data), .clear_err(clear_err), .count(count), .dir(dir),
    .step(step), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cnt;
    logic       dir;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         steps_seen = 0;
  logic [1:0] model_ab;
  logic [7:0] model_cnt;
  logic       model_dir;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // A step pulse is the DUT presenting a result; each pops one expectation.
  always @(negedge clk) begin
    if (!reset && step === 1'b1) begin
      steps_seen++;
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_step: got step=1 count=%0h, expected no step", count);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_count", {24'd0, count}, {24'd0, e.cnt});
        chk("sb_dir", {31'd0, dir}, {31'd0, e.dir});
        chk("sb_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Drive a new {A,B}; a legal move is expected on step three edges later.
  task automatic drive(input logic [1:0] ab);
    logic up, dn;
    up = (model_ab == 2'b00 && ab == 2'b01) || (model_ab == 2'b01 && ab == 2'b11) ||
         (model_ab == 2'b11 && ab == 2'b10) || (model_ab == 2'b10 && ab == 2'b00);
    dn = (model_ab == 2'b00 && ab == 2'b10) || (model_ab == 2'b10 && ab == 2'b11) ||
         (model_ab == 2'b11 && ab == 2'b01) || (model_ab == 2'b01 && ab == 2'b00);
    {a_in, b_in} = ab;
    model_ab = ab;
    if (up || dn) begin
      model_cnt = up ? model_cnt + 8'd1 : model_cnt - 8'd1;
      model_dir = up;
      sb_q.push_back('{cnt: model_cnt, dir: model_dir, cyc: cyc + 3});
    end
    tick(4);
  endtask

  initial begin
    int base;
    reset = 1'b1; {a_in, b_in} = 2'b00; load = 1'b0; data = 8'h00; clear_err = 1'b0;
    model_ab = 2'b00; model_cnt = 8'h00; model_dir = 1'b0;
    tick(2);
    chk("rst_count", {24'd0, count}, 32'd0);
    chk("rst_dir", {31'd0, dir}, 32'd0);
    chk("rst_step", {31'd0, step}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    tick(5);

    base = steps_seen;
    for (int i = 0; i < 8; i++) begin
      drive(2'b01); drive(2'b11); drive(2'b10); drive(2'b00);
    end
    chk("up32_count", {24'd0, count}, 32'd32);
    chk("up32_dir", {31'd0, dir}, 32'd1);
    chk("up32_steps", steps_seen - base, 32'd32);
    chk("up32_err", {31'd0, err}, 32'd0);

    load = 1'b1; data = 8'h02;
    tick(1);
    load = 1'b0; model_cnt = 8'h02;
    chk("load_count", {24'd0, count}, 32'h02);
    drive(2'b10); drive(2'b11); drive(2'b01); drive(2'b00);
    chk("down_wrap_count", {24'd0, count}, 32'hFE);
    chk("down_dir", {31'd0, dir}, 32'd0);

    drive(2'b11);
    chk("illegal_err", {31'd0, err}, 32'd1);
    chk("illegal_count", {24'd0, count}, 32'hFE);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    chk("clear_err", {31'd0, err}, 32'd0);
    drive(2'b10);
    chk("after_err_count", {24'd0, count}, 32'hFF);

    drive(2'b11);
    chk("pre_load_dir", {31'd0, dir}, 32'd0);
    {a_in, b_in} = 2'b10; model_ab = 2'b10;
    tick(2);
    load = 1'b1; data = 8'h55;
    tick(1);
    load = 1'b0; model_cnt = 8'h55; model_dir = 1'b1;
    chk("load_win_count", {24'd0, count}, 32'h55);
    chk("load_win_step", {31'd0, step}, 32'd0);
    chk("load_win_dir", {31'd0, dir}, 32'd1);
    tick(2);

    {a_in, b_in} = 2'b00; model_ab = 2'b00; model_cnt = 8'h56;
    sb_q.push_back('{cnt: 8'h56, dir: 1'b1, cyc: cyc + 3});
    tick(1);
    chk("lat_k", {24'd0, count}, 32'h55);
    tick(1);
    chk("lat_k1_count", {24'd0, count}, 32'h55);
    chk("lat_k1_step", {31'd0, step}, 32'd0);
    tick(1);
    chk("lat_k2_count", {24'd0, count}, 32'h56);
    chk("lat_k2_step", {31'd0, step}, 32'd1);
    tick(2);

    drive(2'b01); drive(2'b11);
    chk("pre_reset_count", {24'd0, count}, 32'h58);
    reset = 1'b1;
    tick(1);
    reset = 1'b0; model_cnt = 8'h00; model_dir = 1'b0;
    chk("midrst_count", {24'd0, count}, 32'd0);
    chk("midrst_dir", {31'd0, dir}, 32'd0);
    base = steps_seen;
    tick(6);
    chk("arm_steps", steps_seen - base, 32'd0);
    chk("arm_err", {31'd0, err}, 32'd0);
    chk("arm_count", {24'd0, count}, 32'd0);
    drive(2'b10);
    chk("post_arm_count", {24'd0, count}, 32'd1);

    tick(4);
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the position counter width in bits.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  reset; one clock, reset synchronous and active-high.
REQ-004 The block SHALL have port a_in  input  1  quadrature channel A; asynchronous to clk.
REQ-005 The block SHALL have port b_in  input  1  quadrature channel B; asynchronous to clk.
REQ-006 The block SHALL have port load  input  1  synchronous load of count from data.
REQ-007 The block SHALL have port data  input  WIDTH  load value.
REQ-008 The block SHALL have port clear_err  input  1  clears the sticky error flag.
REQ-009 The block SHALL have port count  output  WIDTH  registered position count.
REQ-010 The block SHALL have port dir  output  1  registered direction of last valid step: 1 = up, 0 = down.
REQ-011 The block SHALL have port step  output  1  one-cycle pulse marking a count change caused by a valid step.
REQ-012 The block SHALL have port err  output  1  sticky flag for an illegal quadrature transition.

Function
REQ-013 The block SHALL pass a_in and b_in through a two-flop synchronizer (s1, s2) and SHALL hold the previous synchronized pair in register p, reloaded from s2 every non-reset cycle.
REQ-014 The block SHALL decode {A,B} transitions p->s2 as follows:
- Up: 00->01, 01->11, 11->10, 10->00.
- Down: 00->10, 10->11, 11->01, 01->00.
- Idle: no change.
- Illegal: both bits change.
REQ-015 On an up step the block SHALL set count <= count+1 modulo 2^WIDTH, so all-ones wraps to 0.
REQ-016 On a down step the block SHALL set count <= count-1 modulo 2^WIDTH, so 0 wraps to all-ones.
REQ-017 On a valid step the block SHALL set dir to the step direction in the same edge that updates count; dir SHALL hold otherwise.
REQ-018 The block SHALL assert step for exactly one cycle, registered with the count update; step SHALL be 0 on idle, illegal and load cycles.
REQ-019 Latency: a valid input change first sampled at rising edge k SHALL appear on count, dir and step after edge k+2.
REQ-020 An illegal transition SHALL set err <= 1 and SHALL leave count and dir unchanged; the decoder SHALL resynchronize on the new state held in p.
REQ-021 err SHALL remain 1 until clear_err=1 or reset; if clear_err and an illegal transition occur in the same cycle, err SHALL be 1 (set wins).
REQ-022 load=1 SHALL set count <= data, overriding any same-cycle step; dir and err SHALL still update from the decode.
REQ-023 Priority SHALL be: reset > load > step decode.

Reset
REQ-024 reset=1 at a rising edge SHALL clear count, dir, step, err, s1, s2, p and an arm counter to 0, regardless of load or inputs, including mid-sequence.
REQ-025 After reset deasserts, the arm counter SHALL increment each cycle, saturating at 3; decode (step and err generation) SHALL be enabled only at edges where arm==3 before the edge, i.e. from the 4th edge after reset release.
REQ-026 Transitions seen while arm<3 SHALL neither count nor flag an error, so an input held at 11 through reset SHALL produce no spurious step or err.

Verification
REQ-027 The bench SHALL cover: reset, then 8 full up cycles (32 transitions) with WIDTH=8 -> count=32, dir=1, 32 step pulses, err=0.
REQ-028 The bench SHALL cover: load data=8'h02, then 4 down transitions -> count=8'hFE (wrap through 0), dir=0.
REQ-029 The bench SHALL cover: a direct jump 00->11 -> err=1 with count unchanged; then clear_err pulse -> err=0; then one legal up step -> count+1.
REQ-030 The bench SHALL cover: load=1 with data=8'h55 in the same cycle a valid up step is decoded -> count=8'h55, step=0, dir=1.
REQ-031 The bench SHALL cover: inputs held at 11 while reset pulses high mid-count -> count=0, no step and no err during the 3 arming edges; then 11->10 -> count=1.
REQ-032 The bench SHALL cover: an A edge at cycle k -> count changes only after edge k+2, checked cycle-exact.
